sweep_ctrl: RTL

Frequency-sweep sequencer for the DDS phase-accumulator address generator. It drives the generator's frequency word and enable, stepping the frequency from a start value to a stop value (up or down). Each frequency is held for a programmable number of sample-clock ticks. It supports single-pass and repeat modes, with a start/stop/busy/done handshake toward the host/register block.

---
 rtl/sweep_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS address generator.
// Steps f_set from a start to a stop frequency (up or down), holding each
// value for a programmable number of sample-clock ticks, with single-pass or
// repeat operation and a start/stop/busy/done host handshake.
module sweep_ctrl #(
  parameter int FW    = 19,
  parameter int DW    = 16,
  parameter int F_MIN = 1,
  parameter int F_MAX = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_clk,
  input  logic          start,
  input  logic          stop,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic          repeat_mode,
  output logic [FW-1:0] f_set,
  output logic          en,
  output logic          busy,
  output logic          done,
  output logic          pass_tick
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_STEP,
    S_END
  } state_t;

  localparam logic [FW-1:0] F_LO = FW'(F_MIN);
  localparam logic [FW-1:0] F_HI = FW'(F_MAX);

  function automatic logic [FW-1:0] clamp_f(input logic [FW-1:0] v);
    if (v < F_LO)      return F_LO;
    else if (v > F_HI) return F_HI;
    else               return v;
  endfunction

  state_t        state, state_nxt;
  logic          pl0, pl1, tick;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [FW-1:0] f_set_nxt;
  logic          en_nxt, busy_nxt, done_nxt, pass_nxt;
  logic          load;

  // Latched sweep configuration (valid while busy).
  logic [FW-1:0] c_start, c_stop, c_step;
  logic [DW-1:0] c_dwell;
  logic          c_down;

  // Sanitised versions of the live config inputs, captured on load.
  logic [FW-1:0] start_cl, stop_cl, step_eff;
  logic [DW-1:0] dwell_eff;

  // Arithmetic one bit wider than the word so up-steps cannot wrap.
  logic [FW:0]   up_sum, gap;

  assign start_cl  = clamp_f(f_start);
  assign stop_cl   = clamp_f(f_stop);
  assign step_eff  = (f_step == '0) ? FW'(1) : f_step;
  assign dwell_eff = (dwell == '0) ? DW'(1) : dwell;
  assign tick      = pl0 & ~pl1;
  assign up_sum    = {1'b0, f_set} + {1'b0, c_step};
  assign gap       = {1'b0, f_set} - {1'b0, c_stop};

  // Next-state and next-output decode for the sweep FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    f_set_nxt = f_set;
    en_nxt    = en;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = 1'b0;
    load      = 1'b0;

    if (stop && state != S_IDLE) begin
      // Abort: drop everything, no completion pulses.
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      f_set_nxt = '0;
      en_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            load      = 1'b1;
            state_nxt = S_DWELL;
            cnt_nxt   = '0;
            f_set_nxt = start_cl;
            en_nxt    = 1'b1;
            busy_nxt  = 1'b1;
          end
        end
        S_DWELL: begin
          if (tick) begin
            if (cnt == c_dwell - DW'(1)) begin
              cnt_nxt   = '0;
              state_nxt = (f_set != c_stop) ? S_STEP : S_END;
            end else begin
              cnt_nxt = cnt + DW'(1);
            end
          end
        end
        S_STEP: begin
          // The last step is clipped so f_set lands exactly on c_stop.
          if (!c_down) begin
            if (up_sum >= {1'b0, c_stop}) f_set_nxt = c_stop;
            else                          f_set_nxt = up_sum[FW-1:0];
          end else begin
            if (gap <= {1'b0, c_step}) f_set_nxt = c_stop;
            else                       f_set_nxt = f_set - c_step;
          end
          state_nxt = S_DWELL;
        end
        S_END: begin
          pass_nxt = 1'b1;
          if (repeat_mode) begin
            f_set_nxt = c_start;
            state_nxt = S_DWELL;
          end else begin
            done_nxt  = 1'b1;
            en_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, datapath, synchroniser and config registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= S_IDLE;
      pl0       <= 1'b0;
      pl1       <= 1'b0;
      cnt       <= '0;
      f_set     <= '0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_tick <= 1'b0;
      c_start   <= '0;
      c_stop    <= '0;
      c_step    <= '0;
      c_dwell   <= '0;
      c_down    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pl0       <= s_clk;
      pl1       <= pl0;
      cnt       <= cnt_nxt;
      f_set     <= f_set_nxt;
      en        <= en_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass_tick <= pass_nxt;
      if (load) begin
        c_start <= start_cl;
        c_stop  <= stop_cl;
        c_step  <= step_eff;
        c_dwell <= dwell_eff;
        c_down  <= (start_cl > stop_cl);
      end
    end
  end

endmodule
